// File: rtl/hack_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_kbd_pkg
//  Description : Shared Hack keyboard constants (key codes 128-152, memory-map
//                address of the keyboard register) and the PS/2 receive FSM
//                state encoding. Also imported by the CPU memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_kbd_pkg;

    // Hack memory-mapped keyboard register
    localparam logic [15:0] c_hack_kbd_addr  = 16'd24576;

    // Hack special key codes
    localparam logic [7:0]  c_key_newline    = 8'd128;
    localparam logic [7:0]  c_key_backspace  = 8'd129;
    localparam logic [7:0]  c_key_left       = 8'd130;
    localparam logic [7:0]  c_key_up         = 8'd131;
    localparam logic [7:0]  c_key_right      = 8'd132;
    localparam logic [7:0]  c_key_down       = 8'd133;
    localparam logic [7:0]  c_key_home       = 8'd134;
    localparam logic [7:0]  c_key_end        = 8'd135;
    localparam logic [7:0]  c_key_pgup       = 8'd136;
    localparam logic [7:0]  c_key_pgdn       = 8'd137;
    localparam logic [7:0]  c_key_insert     = 8'd138;
    localparam logic [7:0]  c_key_delete     = 8'd139;
    localparam logic [7:0]  c_key_esc        = 8'd140;
    localparam logic [7:0]  c_key_f1         = 8'd141;   // F2..F12 follow consecutively

    // Scancode set 2 prefix / modifier bytes
    localparam logic [7:0]  c_sc_ext         = 8'hE0;
    localparam logic [7:0]  c_sc_brk         = 8'hF0;
    localparam logic [7:0]  c_sc_lshift      = 8'h12;
    localparam logic [7:0]  c_sc_rshift      = 8'h59;

    // PS/2 frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_if
//  Description : PS/2 keyboard bundle. ps2_clk/ps2_data come from the
//                keyboard; key_code, scan_byte, scan_valid, frame_err go to
//                the Hack system.
//                master : keyboard/host side (drives the PS/2 lines)
//                slave  : ps2_keyboard block
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key_code;
    logic [7:0]  scan_byte;
    logic        scan_valid;
    logic        frame_err;

    modport master (output ps2_clk, ps2_data,
                    input  key_code, scan_byte, scan_valid, frame_err);
    modport slave  (input  ps2_clk, ps2_data,
                    output key_code, scan_byte, scan_valid, frame_err);
endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 frame receiver. Synchronizes and deglitches the PS/2
//                lines, receives start/8 data/odd parity/stop frames on
//                falling edges of ps2_clk, aborts frames on timeout.
//  Ports       : clk, rst        - system clock, sync active-high reset
//                i_ps2_clk/data  - raw asynchronous PS/2 lines
//                o_scan_byte     - last good byte
//                o_scan_valid    - 1-cycle pulse when o_scan_byte updates
//                o_frame_err     - 1-cycle pulse on parity/stop/timeout error
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 200
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_ps2_clk,
    input  wire logic       i_ps2_data,
    output logic [7:0]      o_scan_byte,
    output logic            o_scan_valid,
    output logic            o_frame_err
);

    localparam int                  c_timeout_cyc = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int                  c_to_w        = $clog2(c_timeout_cyc + 1);
    localparam logic [c_to_w-1:0]   c_timeout_v   = c_to_w'(c_timeout_cyc);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_clk_db;
    logic              r_clk_db_q;
    logic [2:0]        r_db_cnt;
    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par_ok;
    logic [c_to_w-1:0] r_to_cnt;
    logic [7:0]        r_scan_byte;
    logic              r_scan_valid;
    logic              r_frame_err;

    logic              w_clk_s;
    logic              w_data_s;
    logic              w_fall;
    logic              w_timeout;
    logic              w_shift_en;
    logic              w_par_en;
    logic              w_valid_nxt;
    logic              w_err_nxt;

    assign w_clk_s   = r_clk_sync[1];
    assign w_data_s  = r_data_sync[1];
    assign w_fall    = r_clk_db_q & ~r_clk_db;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == c_timeout_v);

    // Synchronizers and deglitcher: the filtered clock only follows the
    // synchronized one after 8 consecutive samples that disagree with it.
    // Reset drives the filtered clock low so no false falling edge can
    // appear after reset, whatever level ps2_clk sits at.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b00;
            r_data_sync <= 2'b00;
            r_clk_db    <= 1'b0;
            r_clk_db_q  <= 1'b0;
            r_db_cnt    <= 3'd0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_db_q  <= r_clk_db;
            if (w_clk_s != r_clk_db) begin
                if (r_db_cnt == 3'd7) begin
                    r_clk_db <= w_clk_s;
                    r_db_cnt <= 3'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 3'd1;
                end
            end else begin
                r_db_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_data_s) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_data_s && r_par_ok) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: shift register, bit counter, parity, timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_par_ok     <= 1'b0;
            r_to_cnt     <= '0;
            r_scan_byte  <= 8'd0;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_data_s, r_shift[7:1]};     // LSB arrives first
            end
            if (w_par_en) begin
                r_par_ok <= ^{r_shift, w_data_s};        // odd parity -> XOR is 1
            end
            // Cycles since the last edge; saturates at the timeout value.
            if ((r_state == ST_IDLE) || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_timeout_v) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_valid_nxt) begin
                r_scan_byte <= r_shift;
            end
            r_scan_valid <= w_valid_nxt;
            r_frame_err  <= w_err_nxt;
        end
    end

    assign o_scan_byte  = r_scan_byte;
    assign o_scan_valid = r_scan_valid;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard
//  Description : PS/2 keyboard to Hack keyboard register. Receives scancode
//                set 2 bytes via ps2_rx and decodes make/break sequences into
//                the Hack key code of the currently held key.
//  Ports       : clk, rst - system clock, sync active-high reset
//                bus      - ps2_keyboard_if.slave: ps2_clk, ps2_data in;
//                           key_code, scan_byte, scan_valid, frame_err out
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 200
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ps2_keyboard_if.slave    bus
);

    logic [7:0]  w_scan_byte;
    logic        w_scan_valid;
    logic        w_frame_err;
    logic [8:0]  w_scan;
    logic [7:0]  w_make_code;

    logic        r_ext;
    logic        r_brk;
    logic        r_shift_l;
    logic        r_shift_r;
    logic [8:0]  r_held_scan;
    logic [15:0] r_key_code;

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_data   (bus.ps2_data),
        .o_scan_byte  (w_scan_byte),
        .o_scan_valid (w_scan_valid),
        .o_frame_err  (w_frame_err)
    );

    // {ext, scancode} -> Hack code; 0 means the key has no Hack code.
    function automatic logic [7:0] f_key_lookup(input logic [8:0] scan, input logic shift);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'd0;
        hi = 8'd0;
        case (scan)
            9'h01C: begin lo = "a"; hi = "A"; end   9'h032: begin lo = "b"; hi = "B"; end
            9'h021: begin lo = "c"; hi = "C"; end   9'h023: begin lo = "d"; hi = "D"; end
            9'h024: begin lo = "e"; hi = "E"; end   9'h02B: begin lo = "f"; hi = "F"; end
            9'h034: begin lo = "g"; hi = "G"; end   9'h033: begin lo = "h"; hi = "H"; end
            9'h043: begin lo = "i"; hi = "I"; end   9'h03B: begin lo = "j"; hi = "J"; end
            9'h042: begin lo = "k"; hi = "K"; end   9'h04B: begin lo = "l"; hi = "L"; end
            9'h03A: begin lo = "m"; hi = "M"; end   9'h031: begin lo = "n"; hi = "N"; end
            9'h044: begin lo = "o"; hi = "O"; end   9'h04D: begin lo = "p"; hi = "P"; end
            9'h015: begin lo = "q"; hi = "Q"; end   9'h02D: begin lo = "r"; hi = "R"; end
            9'h01B: begin lo = "s"; hi = "S"; end   9'h02C: begin lo = "t"; hi = "T"; end
            9'h03C: begin lo = "u"; hi = "U"; end   9'h02A: begin lo = "v"; hi = "V"; end
            9'h01D: begin lo = "w"; hi = "W"; end   9'h022: begin lo = "x"; hi = "X"; end
            9'h035: begin lo = "y"; hi = "Y"; end   9'h01A: begin lo = "z"; hi = "Z"; end
            9'h016: begin lo = "1"; hi = "!"; end   9'h01E: begin lo = "2"; hi = "@"; end
            9'h026: begin lo = "3"; hi = "#"; end   9'h025: begin lo = "4"; hi = "$"; end
            9'h02E: begin lo = "5"; hi = "%"; end   9'h036: begin lo = "6"; hi = "^"; end
            9'h03D: begin lo = "7"; hi = "&"; end   9'h03E: begin lo = "8"; hi = "*"; end
            9'h046: begin lo = "9"; hi = "("; end   9'h045: begin lo = "0"; hi = ")"; end
            9'h00E: begin lo = 8'h60; hi = "~"; end 9'h04E: begin lo = "-"; hi = "_"; end
            9'h055: begin lo = "="; hi = "+"; end   9'h054: begin lo = "["; hi = "{"; end
            9'h05B: begin lo = "]"; hi = "}"; end   9'h05D: begin lo = "\\"; hi = "|"; end
            9'h04C: begin lo = ";"; hi = ":"; end   9'h052: begin lo = "'"; hi = "\""; end
            9'h041: begin lo = ","; hi = "<"; end   9'h049: begin lo = "."; hi = ">"; end
            9'h04A: begin lo = "/"; hi = "?"; end   9'h029: begin lo = " "; hi = " "; end
            9'h05A: begin lo = c_key_newline;   hi = lo; end
            9'h066: begin lo = c_key_backspace; hi = lo; end
            9'h076: begin lo = c_key_esc;       hi = lo; end
            9'h16B: begin lo = c_key_left;      hi = lo; end
            9'h175: begin lo = c_key_up;        hi = lo; end
            9'h174: begin lo = c_key_right;     hi = lo; end
            9'h172: begin lo = c_key_down;      hi = lo; end
            9'h16C: begin lo = c_key_home;      hi = lo; end
            9'h169: begin lo = c_key_end;       hi = lo; end
            9'h17D: begin lo = c_key_pgup;      hi = lo; end
            9'h17A: begin lo = c_key_pgdn;      hi = lo; end
            9'h170: begin lo = c_key_insert;    hi = lo; end
            9'h171: begin lo = c_key_delete;    hi = lo; end
            9'h005: begin lo = c_key_f1;          hi = lo; end
            9'h006: begin lo = c_key_f1 + 8'd1;   hi = lo; end
            9'h004: begin lo = c_key_f1 + 8'd2;   hi = lo; end
            9'h00C: begin lo = c_key_f1 + 8'd3;   hi = lo; end
            9'h003: begin lo = c_key_f1 + 8'd4;   hi = lo; end
            9'h00B: begin lo = c_key_f1 + 8'd5;   hi = lo; end
            9'h083: begin lo = c_key_f1 + 8'd6;   hi = lo; end
            9'h00A: begin lo = c_key_f1 + 8'd7;   hi = lo; end
            9'h001: begin lo = c_key_f1 + 8'd8;   hi = lo; end
            9'h009: begin lo = c_key_f1 + 8'd9;   hi = lo; end
            9'h078: begin lo = c_key_f1 + 8'd10;  hi = lo; end
            9'h007: begin lo = c_key_f1 + 8'd11;  hi = lo; end
            default: begin lo = 8'd0; hi = 8'd0; end
        endcase
        return shift ? hi : lo;
    endfunction

    assign w_scan      = {r_ext, w_scan_byte};
    assign w_make_code = f_key_lookup(w_scan, r_shift_l | r_shift_r);

    // Frame errors never reach this logic: only scan_valid bytes are decoded,
    // so ext/brk/key_code survive a corrupted frame untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_held_scan <= 9'd0;
            r_key_code  <= 16'd0;
        end else if (w_scan_valid) begin
            if (w_scan_byte == c_sc_ext) begin
                r_ext <= 1'b1;
            end else if (w_scan_byte == c_sc_brk) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_scan_byte == c_sc_lshift) begin
                    r_shift_l <= ~r_brk;
                end else if (w_scan_byte == c_sc_rshift) begin
                    r_shift_r <= ~r_brk;
                end else if (!r_brk) begin
                    // Typematic repeats reload the same value directly.
                    if (w_make_code != 8'd0) begin
                        r_key_code  <= {8'd0, w_make_code};
                        r_held_scan <= w_scan;
                    end
                end else if (w_scan == r_held_scan) begin
                    r_key_code <= 16'd0;
                end
            end
        end
    end

    assign bus.key_code   = r_key_code;
    assign bus.scan_byte  = w_scan_byte;
    assign bus.scan_valid = w_scan_valid;
    assign bus.frame_err  = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_keyboard
//  Description : Directed self-checking bench for ps2_keyboard. clk runs at
//                1 MHz (CLK_HZ=1_000_000, so the 200 us timeout is 200
//                cycles); the PS/2 clock runs at 12.5 kHz (80-cycle bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_keyboard_if bus();

    ps2_keyboard #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #500 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Passive monitor of output pulses (sampled on the falling clk edge).
    int          valid_cnt      = 0;
    int          err_cnt        = 0;
    logic [7:0]  last_byte      = 8'd0;
    logic [15:0] kc_at_valid    = 16'd0;
    logic [15:0] kc_after_valid = 16'd0;
    logic        valid_d        = 1'b0;
    logic        glitch_watch   = 1'b0;
    logic        glitch_seen    = 1'b0;

    always @(negedge clk) begin
        if (valid_d === 1'b1) kc_after_valid <= bus.key_code;
        valid_d <= bus.scan_valid;
        if (bus.scan_valid === 1'b1) begin
            valid_cnt   <= valid_cnt + 1;
            last_byte   <= bus.scan_byte;
            kc_at_valid <= bus.key_code;
        end
        if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (glitch_watch && bus.key_code == 16'd0) glitch_seen <= 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        repeat (20) @(posedge clk);
        bus.ps2_clk = 1'b0;
        repeat (40) @(posedge clk);
        bus.ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad_par);
        ps2_bit(stop);
        bus.ps2_data = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL reset key_code: got %0d expected 0", bus.key_code); else n_pass++;
        n_total++; if (bus.scan_byte !== 8'd0) $display("FAIL reset scan_byte: got %h expected 00", bus.scan_byte); else n_pass++;
        n_total++; if (bus.scan_valid !== 1'b0) $display("FAIL reset scan_valid: got %b expected 0", bus.scan_valid); else n_pass++;
        n_total++; if (bus.frame_err !== 1'b0) $display("FAIL reset frame_err: got %b expected 0", bus.frame_err); else n_pass++;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_single_make();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h1C);
        n_total++; if (valid_cnt !== v0 + 1) $display("FAIL make_1c valid pulses: got %0d expected %0d", valid_cnt - v0, 1); else n_pass++;
        n_total++; if (last_byte !== 8'h1C) $display("FAIL make_1c scan_byte: got %h expected 1c", last_byte); else n_pass++;
        n_total++; if (kc_at_valid !== 16'd0) $display("FAIL make_1c key_code during scan_valid: got %0d expected 0", kc_at_valid); else n_pass++;
        n_total++; if (kc_after_valid !== 16'd97) $display("FAIL make_1c key_code one cycle later: got %0d expected 97", kc_after_valid); else n_pass++;
        n_total++; if (err_cnt !== e0) $display("FAIL make_1c frame_err pulses: got %0d expected 0", err_cnt - e0); else n_pass++;
        send_byte(8'hF0); send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL break_1c key_code: got %0d expected 0", bus.key_code); else n_pass++;
    endtask

    task automatic test_shift();
        send_byte(8'h12);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL shift_make key_code: got %0d expected 0", bus.key_code); else n_pass++;
        send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd65) $display("FAIL shift_a key_code: got %0d expected 65", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL shift_a_break key_code: got %0d expected 0", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd97) $display("FAIL unshift_a key_code: got %0d expected 97", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'h59); send_byte(8'h16);
        n_total++; if (bus.key_code !== 16'd33) $display("FAIL rshift_1 key_code: got %0d expected 33", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h16);
        send_byte(8'hF0); send_byte(8'h59);
        send_byte(8'h4E);
        n_total++; if (bus.key_code !== 16'd45) $display("FAIL minus key_code: got %0d expected 45", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h4E);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL minus_break key_code: got %0d expected 0", bus.key_code); else n_pass++;
    endtask

    task automatic test_ext();
        send_byte(8'hE0); send_byte(8'h75);
        n_total++; if (bus.key_code !== 16'd131) $display("FAIL ext_up key_code: got %0d expected 131", bus.key_code); else n_pass++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL ext_up_break key_code: got %0d expected 0", bus.key_code); else n_pass++;
        send_byte(8'h75);   // keypad 8 without E0: no Hack code
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL kp8_unmapped key_code: got %0d expected 0", bus.key_code); else n_pass++;
        send_byte(8'hE0); send_byte(8'h71);
        n_total++; if (bus.key_code !== 16'd139) $display("FAIL ext_delete key_code: got %0d expected 139", bus.key_code); else n_pass++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h71);
    endtask

    task automatic test_special_keys();
        send_byte(8'h05);
        n_total++; if (bus.key_code !== 16'd141) $display("FAIL f1 key_code: got %0d expected 141", bus.key_code); else n_pass++;
        send_byte(8'h07);
        n_total++; if (bus.key_code !== 16'd152) $display("FAIL f12 key_code: got %0d expected 152", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h05);   // F1 no longer the held key
        n_total++; if (bus.key_code !== 16'd152) $display("FAIL f1_break_not_held key_code: got %0d expected 152", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h07);
        send_byte(8'h76);
        n_total++; if (bus.key_code !== 16'd140) $display("FAIL esc key_code: got %0d expected 140", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h76);
        send_byte(8'h66);
        n_total++; if (bus.key_code !== 16'd129) $display("FAIL backspace key_code: got %0d expected 129", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h66);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h1C);
        glitch_seen  = 1'b0;
        glitch_watch = 1'b1;
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        glitch_watch = 1'b0;
        n_total++; if (glitch_seen !== 1'b0) $display("FAIL typematic glitch through 0: got %b expected 0", glitch_seen); else n_pass++;
        n_total++; if (bus.key_code !== 16'd97) $display("FAIL typematic key_code: got %0d expected 97", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h32);
        n_total++; if (bus.key_code !== 16'd97) $display("FAIL other_break key_code: got %0d expected 97", bus.key_code); else n_pass++;
        send_byte(8'hF0); send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL typematic_release key_code: got %0d expected 0", bus.key_code); else n_pass++;
    endtask

    task automatic test_frame_error();
        int v0, e0;
        send_byte(8'h1C);
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        n_total++; if (err_cnt !== e0 + 1) $display("FAIL parity frame_err pulses: got %0d expected 1", err_cnt - e0); else n_pass++;
        n_total++; if (valid_cnt !== v0) $display("FAIL parity scan_valid pulses: got %0d expected 0", valid_cnt - v0); else n_pass++;
        n_total++; if (bus.key_code !== 16'd97) $display("FAIL parity key_code: got %0d expected 97", bus.key_code); else n_pass++;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++; if (err_cnt !== e0 + 2) $display("FAIL stop frame_err pulses: got %0d expected 2", err_cnt - e0); else n_pass++;
        n_total++; if (valid_cnt !== v0) $display("FAIL stop scan_valid pulses: got %0d expected 0", valid_cnt - v0); else n_pass++;
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0);
        send_frame(8'h33, 1'b1, 1'b1);   // corrupted frame must not clear ext
        send_byte(8'h75);
        n_total++; if (bus.key_code !== 16'd131) $display("FAIL ext_after_err key_code: got %0d expected 131", bus.key_code); else n_pass++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL ext_after_err_break key_code: got %0d expected 0", bus.key_code); else n_pass++;
    endtask

    task automatic test_timeout();
        int v0, e0;
        logic [7:0] b;
        b = 8'h29;
        v0 = valid_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        bus.ps2_data = 1'b1;
        repeat (250) @(posedge clk);
        @(negedge clk);
        n_total++; if (err_cnt !== e0 + 1) $display("FAIL timeout frame_err pulses: got %0d expected 1", err_cnt - e0); else n_pass++;
        n_total++; if (valid_cnt !== v0) $display("FAIL timeout scan_valid pulses: got %0d expected 0", valid_cnt - v0); else n_pass++;
        send_byte(8'h29);
        n_total++; if (bus.key_code !== 16'd32) $display("FAIL after_timeout space key_code: got %0d expected 32", bus.key_code); else n_pass++;
        n_total++; if (err_cnt !== e0 + 1) $display("FAIL after_timeout frame_err pulses: got %0d expected 1", err_cnt - e0); else n_pass++;
        send_byte(8'hF0); send_byte(8'h29);
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_byte(8'h1C);
        n_total++; if (bus.key_code !== 16'd97) $display("FAIL pre_reset key_code: got %0d expected 97", bus.key_code); else n_pass++;
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        e0 = err_cnt;
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL midframe_reset key_code: got %0d expected 0", bus.key_code); else n_pass++;
        n_total++; if (bus.scan_byte !== 8'd0) $display("FAIL midframe_reset scan_byte: got %h expected 00", bus.scan_byte); else n_pass++;
        bus.ps2_data = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        n_total++; if (err_cnt !== e0) $display("FAIL midframe_reset stray frame_err: got %0d expected 0", err_cnt - e0); else n_pass++;
        send_byte(8'h5A);
        n_total++; if (bus.key_code !== 16'd128) $display("FAIL enter_after_reset key_code: got %0d expected 128", bus.key_code); else n_pass++;
        n_total++; if (last_byte !== 8'h5A) $display("FAIL enter_after_reset scan_byte: got %h expected 5a", last_byte); else n_pass++;
        send_byte(8'hF0); send_byte(8'h5A);
        n_total++; if (bus.key_code !== 16'd0) $display("FAIL enter_break key_code: got %0d expected 0", bus.key_code); else n_pass++;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_single_make();
        test_shift();
        test_ext();
        test_special_keys();
        test_back_to_back();
        test_frame_error();
        test_timeout();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
